// File: rtl/flit_sink_if.sv
// Valid/ready flit channel feeding a node's local ejection-port sink.
// The master drives flits; the slave (the sink) returns flit_ready.
interface flit_sink_if #(
   parameter int FW = 40
);
   logic [FW-1:0] flit_in;
   logic          flit_valid;
   logic          flit_ready;

   modport master (
      output flit_in,
      output flit_valid,
      input  flit_ready
   );

   modport slave (
      input  flit_in,
      input  flit_valid,
      output flit_ready
   );
endinterface

// File: rtl/flit_sink.sv
// Ejection-port flit sink: enforces header->payload*->tail ordering, checks the
// destination against this node, reports completed packets and keeps saturating stats.
module flit_sink #(
   parameter int         FW      = 40,
   parameter int         MAX_LEN = 16,
   parameter int         CNT_W   = 16,
   parameter logic [3:0] LOCAL_X = 4'd2,
   parameter logic [3:0] LOCAL_Y = 4'd1,
   parameter logic [3:0] LOCAL_Z = 4'd3
) (
   input  logic             clk,
   input  logic             rst,
   flit_sink_if.slave       link,
   input  logic             clr_stats,
   output logic             pkt_done,
   output logic [11:0]      pkt_src,
   output logic [7:0]       pkt_len,
   output logic             pkt_err,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] pkt_count,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {
      IDLE,
      BODY,
      DONE,
      DROP
   } state_t;

   typedef enum logic [1:0] {
      T_IDLE = 2'b00,
      T_TAIL = 2'b01,
      T_PAY  = 2'b10,
      T_HEAD = 2'b11
   } ftype_t;

   typedef enum logic [1:0] {
      E_NONE  = 2'b00,
      E_SEQ   = 2'b01,
      E_ROUTE = 2'b10,
      E_LEN   = 2'b11
   } err_t;

   localparam logic [11:0]      LOCAL_ADDR = {LOCAL_X, LOCAL_Y, LOCAL_Z};
   localparam logic [7:0]       LEN_LAST   = 8'(MAX_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t      state;
   logic        ready;
   logic [7:0]  len;
   logic [11:0] cur_src;

   ftype_t      ftype;
   logic        accept;
   logic [11:0] hdr_src;
   logic [11:0] hdr_dst;
   logic        dst_ok;
   logic        done_fire;
   logic        err_fire;
   err_t        err_kind;
   logic        unused_bits;

   assign ftype       = ftype_t'(link.flit_in[FW-1 -: 2]);
   assign hdr_src     = link.flit_in[FW-3 -: 12];
   assign hdr_dst     = link.flit_in[FW-15 -: 12];
   assign unused_bits = ^link.flit_in[FW-27:0];
   assign dst_ok      = (hdr_dst == LOCAL_ADDR);
   assign accept      = link.flit_valid & ready;
   assign link.flit_ready = ready;

   // Event decode for the flit being accepted this cycle; at most one error per flit.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      done_fire = 1'b0;
      err_fire  = 1'b0;
      err_kind  = E_NONE;
      if (accept) begin
         unique case (state)
            IDLE: begin
               if (ftype == T_PAY || ftype == T_TAIL) begin
                  err_fire = 1'b1;
                  err_kind = E_SEQ;
               end else if (ftype == T_HEAD && !dst_ok) begin
                  err_fire = 1'b1;
                  err_kind = E_ROUTE;
               end
            end
            BODY: begin
               // A header here ends the open packet; it is reported as a sequence error only.
               if (ftype == T_HEAD) begin
                  err_fire = 1'b1;
                  err_kind = E_SEQ;
               end else if (ftype == T_PAY && len == LEN_LAST) begin
                  err_fire = 1'b1;
                  err_kind = E_LEN;
               end else if (ftype == T_TAIL) begin
                  done_fire = 1'b1;
               end
            end
            DROP: begin
               if (ftype == T_HEAD && !dst_ok) begin
                  err_fire = 1'b1;
                  err_kind = E_ROUTE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ready     <= 1'b0;
         len       <= 8'd0;
         cur_src   <= 12'd0;
         pkt_done  <= 1'b0;
         pkt_src   <= 12'd0;
         pkt_len   <= 8'd0;
         pkt_err   <= 1'b0;
         err_code  <= 2'b00;
         pkt_count <= '0;
         err_count <= '0;
      end else begin
         // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
         ready    <= 1'b1;
         pkt_done <= done_fire;
         pkt_err  <= err_fire;
         err_code <= err_fire ? err_kind : E_NONE;

         if (done_fire) begin
            pkt_src <= cur_src;
            pkt_len <= len + 8'd1;
         end

         if (clr_stats) begin
            pkt_count <= '0;
         end else if (done_fire && pkt_count != CNT_MAX) begin
            pkt_count <= pkt_count + CNT_ONE;
         end

         if (clr_stats) begin
            err_count <= '0;
         end else if (err_fire && err_count != CNT_MAX) begin
            err_count <= err_count + CNT_ONE;
         end

         unique case (state)
            IDLE, DROP: begin
               if (accept) begin
                  if (ftype == T_HEAD) begin
                     cur_src <= hdr_src;
                     len     <= 8'd1;
                     state   <= dst_ok ? BODY : DROP;
                  end else if (state == DROP && ftype == T_TAIL) begin
                     state <= IDLE;
                  end
               end
            end
            BODY: begin
               if (accept) begin
                  unique case (ftype)
                     T_HEAD: begin
                        cur_src <= hdr_src;
                        len     <= 8'd1;
                        state   <= dst_ok ? BODY : DROP;
                     end
                     T_PAY: begin
                        if (len == LEN_LAST) begin
                           state <= DROP;
                        end else begin
                           len <= len + 8'd1;
                        end
                     end
                     T_TAIL: begin
                        len   <= len + 8'd1;
                        state <= DONE;
                        ready <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flit_sink.sv
// Self-checking bench for flit_sink: directed scenarios then randomized traffic,
// all compared every cycle against a packet-level reference model.
module tb_flit_sink;

   localparam int          MAX_LEN = 16;
   localparam int          CNT_W   = 4;
   localparam int          CNT_MAX = 15;
   localparam logic [11:0] LOCAL   = 12'h213;

   logic             clk = 1'b0;
   logic             rst;
   logic             clr_stats;
   logic             pkt_done;
   logic [11:0]      pkt_src;
   logic [7:0]       pkt_len;
   logic             pkt_err;
   logic [1:0]       err_code;
   logic [CNT_W-1:0] pkt_count;
   logic [CNT_W-1:0] err_count;

   flit_sink_if #(.FW(40)) bus ();

   flit_sink #(
      .FW     (40),
      .MAX_LEN(MAX_LEN),
      .CNT_W  (CNT_W),
      .LOCAL_X(4'd2),
      .LOCAL_Y(4'd1),
      .LOCAL_Z(4'd3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .link     (bus),
      .clr_stats(clr_stats),
      .pkt_done (pkt_done),
      .pkt_src  (pkt_src),
      .pkt_len  (pkt_len),
      .pkt_err  (pkt_err),
      .err_code (err_code),
      .pkt_count(pkt_count),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: packet-level view of the stream.
   logic        m_in_pkt, m_drop;
   int          m_len;
   logic [11:0] m_src;
   logic        exp_done, exp_err, exp_ready;
   logic [1:0]  exp_code;
   logic [11:0] exp_src;
   int          exp_len, exp_pc, exp_ec;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [39:0] mk(input logic [1:0] t, input logic [11:0] src, input logic [11:0] dst);
      logic [39:0] f;
      f[31:0]  = $urandom();
      f[39:32] = 8'($urandom());
      f[39:38] = t;
      if (t == 2'b11) begin
         f[37:26] = src;
         f[25:14] = dst;
      end
      return f;
   endfunction

   function automatic logic [39:0] hdr(input logic [11:0] src, input logic [11:0] dst);
      return mk(2'b11, src, dst);
   endfunction

   function automatic logic [39:0] pay();
      return mk(2'b10, 12'd0, 12'd0);
   endfunction

   function automatic logic [39:0] tl();
      return mk(2'b01, 12'd0, 12'd0);
   endfunction

   function automatic logic clr_rand();
      return ($urandom_range(0, 49) == 0);
   endfunction

   task automatic model_step(input logic v, input logic [39:0] f, input logic c, input logic r,
                             output logic acc);
      logic       nd, ne;
      logic [1:0] code, t;
      if (r) begin
         m_in_pkt = 0; m_drop = 0; m_len = 0; m_src = 0;
         exp_done = 0; exp_err = 0; exp_code = 0; exp_src = 0; exp_len = 0;
         exp_pc = 0; exp_ec = 0; exp_ready = 0;
         acc = 0;
      end else begin
         acc  = v && exp_ready;
         nd   = 0;
         ne   = 0;
         code = 2'b00;
         t    = f[39:38];
         if (acc && t != 2'b00) begin
            if (t == 2'b11) begin
               if (m_in_pkt) begin
                  ne = 1; code = 2'b01;
               end else if (f[25:14] != LOCAL) begin
                  ne = 1; code = 2'b10;
               end
               m_src    = f[37:26];
               m_len    = 1;
               m_in_pkt = (f[25:14] == LOCAL);
               m_drop   = !m_in_pkt;
            end else if (!m_in_pkt) begin
               if (m_drop) begin
                  if (t == 2'b01) m_drop = 0;
               end else begin
                  ne = 1; code = 2'b01;
               end
            end else if (t == 2'b10) begin
               if (m_len == MAX_LEN - 1) begin
                  ne = 1; code = 2'b11; m_in_pkt = 0; m_drop = 1;
               end else begin
                  m_len++;
               end
            end else begin
               m_len++;
               nd       = 1;
               m_in_pkt = 0;
               exp_src  = m_src;
               exp_len  = m_len;
            end
         end
         exp_done  = nd;
         exp_err   = ne;
         exp_code  = code;
         exp_pc    = c ? 0 : (nd && exp_pc < CNT_MAX) ? exp_pc + 1 : exp_pc;
         exp_ec    = c ? 0 : (ne && exp_ec < CNT_MAX) ? exp_ec + 1 : exp_ec;
         exp_ready = !nd;
      end
   endtask

   // Drive one cycle at the falling edge, advance the model, then compare at the next falling edge.
   task automatic tick(input logic v, input logic [39:0] f, input logic c, input logic r,
                       output logic acc);
      bus.flit_valid = v;
      bus.flit_in    = f;
      clr_stats      = c;
      rst            = r;
      model_step(v, f, c, r, acc);
      @(negedge clk);
      check("flit_ready", 32'(bus.flit_ready), 32'(exp_ready));
      check("pkt_done",   32'(pkt_done),       32'(exp_done));
      check("pkt_err",    32'(pkt_err),        32'(exp_err));
      if (exp_err) check("err_code", 32'(err_code), 32'(exp_code));
      check("pkt_src",    32'(pkt_src),        32'(exp_src));
      check("pkt_len",    32'(pkt_len),        exp_len);
      check("pkt_count",  32'(pkt_count),      exp_pc);
      check("err_count",  32'(err_count),      exp_ec);
   endtask

   task automatic send(input logic [39:0] f, input logic c);
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < 4 && !acc; i++) tick(1'b1, f, c, 1'b0, acc);
      check("send_accept", 32'(acc), 32'd1);
   endtask

   task automatic idle_cycle(input logic c, input logic r);
      logic acc;
      tick(1'b0, mk(2'b11, 12'($urandom()), LOCAL), c, r, acc);
   endtask

   task automatic noise();
      int r;
      r = $urandom_range(0, 99);
      if (r < 10) idle_cycle(clr_rand(), 1'b0);
      else if (r < 18) send(mk(2'b00, 12'd0, 12'd0), clr_rand());
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      clr_stats      = 1'b0;
      bus.flit_valid = 1'b0;
      bus.flit_in    = '0;
      @(negedge clk);
      repeat (3) idle_cycle(1'b0, 1'b1);
      idle_cycle(1'b0, 1'b0);

      // Basic good packet
      send(hdr(12'h567, LOCAL), 1'b0);
      repeat (3) send(pay(), 1'b0);
      send(tl(), 1'b0);
      check("t1_done",  32'(pkt_done),       32'd1);
      check("t1_len",   32'(pkt_len),        32'd5);
      check("t1_src",   32'(pkt_src),        32'h567);
      check("t1_count", 32'(pkt_count),      32'd1);
      check("t1_ready", 32'(bus.flit_ready), 32'd0);

      // Misroute
      send(hdr(12'h5a5, 12'h113), 1'b0);
      check("t2_err",  32'(pkt_err),  32'd1);
      check("t2_code", 32'(err_code), 32'd2);
      send(pay(), 1'b0);
      send(tl(), 1'b0);
      check("t2_nodone", 32'(pkt_done),  32'd0);
      check("t2_errs",   32'(err_count), 32'd1);

      // Overlength at MAX_LEN
      send(hdr(12'h111, LOCAL), 1'b0);
      repeat (14) send(pay(), 1'b0);
      check("t3_ok15", 32'(pkt_err), 32'd0);
      send(pay(), 1'b0);
      check("t3_err",  32'(pkt_err),  32'd1);
      check("t3_code", 32'(err_code), 32'd3);
      send(hdr(12'h222, LOCAL), 1'b0);
      send(tl(), 1'b0);
      check("t3_done", 32'(pkt_done), 32'd1);
      check("t3_len",  32'(pkt_len),  32'd2);

      // Sequence errors
      send(tl(), 1'b0);
      check("t4_tail_code", 32'(err_code), 32'd1);
      send(hdr(12'h333, LOCAL), 1'b0);
      send(pay(), 1'b0);
      send(hdr(12'h444, LOCAL), 1'b0);
      check("t4_hdr_err",  32'(pkt_err),  32'd1);
      check("t4_hdr_code", 32'(err_code), 32'd1);
      send(pay(), 1'b0);
      send(tl(), 1'b0);
      check("t4_len",   32'(pkt_len),   32'd3);
      check("t4_src",   32'(pkt_src),   32'h444);
      check("t4_errs",  32'(err_count), 32'd4);
      check("t4_count", 32'(pkt_count), 32'd3);

      // Reset mid-packet
      send(hdr(12'h555, LOCAL), 1'b0);
      send(pay(), 1'b0);
      repeat (2) idle_cycle(1'b0, 1'b1);
      idle_cycle(1'b0, 1'b0);
      send(tl(), 1'b0);
      check("t5_nodone", 32'(pkt_done),  32'd0);
      check("t5_code",   32'(err_code),  32'd1);
      check("t5_errs",   32'(err_count), 32'd1);

      // Saturation, then clear together with completion
      for (int p = 0; p < 16; p++) begin
         send(hdr(12'(p), LOCAL), 1'b0);
         send(tl(), 1'b0);
      end
      check("t6_sat", 32'(pkt_count), 32'd15);
      send(hdr(12'h666, LOCAL), 1'b0);
      send(tl(), 1'b1);
      check("t6_done", 32'(pkt_done),  32'd1);
      check("t6_clr",  32'(pkt_count), 32'd0);

      // Randomized traffic
      for (int p = 0; p < 400; p++) begin
         int r;
         r = $urandom_range(0, 99);
         noise();
         if (r < 5) begin
            send(($urandom_range(0, 1) != 0) ? pay() : tl(), clr_rand());
         end else if (r < 7) begin
            repeat ($urandom_range(1, 2)) idle_cycle(1'b0, 1'b1);
         end else begin
            int n;
            logic [11:0] dst;
            dst = ($urandom_range(0, 9) < 8) ? LOCAL : 12'($urandom());
            send(hdr(12'($urandom()), dst), clr_rand());
            n = $urandom_range(0, 17);
            for (int i = 0; i < n; i++) begin
               noise();
               send(pay(), clr_rand());
            end
            noise();
            if ($urandom_range(0, 9) != 0) send(tl(), clr_rand());
         end
      end
      idle_cycle(1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
